data_memory_lanes: RTL and testbench
====================================

Name: data_memory_lanes

Overview:
Parametrised successor to the single-cycle data memory in the datapath's MEM stage. Byte-addressable, little-endian word array that performs true byte and halfword stores through byte-lane masking, and returns loads sign- or zero-extended. Requests use a valid/ready handshake and receive an in-order response after a fixed, configurable latency. Optional post-reset clear sequence, plus misalignment and range fault reporting.

Parameters:
DEPTH_WORDS, 4096, number of 32-bit words; power of two, minimum 16
ADDR_W, 32, byte-address width
READ_LATENCY, 1, cycles from request acceptance to response; legal range 1..4
CLEAR_ON_RESET, 0, 1 = zero every word after reset before accepting requests
INIT_FILE, "", hex image loaded at time zero when non-empty; ignored when CLEAR_ON_RESET=1

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  response present, one-cycle pulse per request
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_err  out  1  request faulted
init_done  out  1  high in READY state

Behaviour:
- Handshake: a request is accepted on a rising edge when req_valid && req_ready. There is no backpressure on the response side.
- Reset (async assert): resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0, init_done=0, and the response pipeline is emptied. Array contents are not touched by rst_n.
- FSM states:
  - RESET: held while rst_n=0. The first edge after release moves to CLEAR if CLEAR_ON_RESET=1, otherwise to READY.
  - CLEAR: writes 0 to word index 0..DEPTH_WORDS-1, one word per cycle. Moves to READY on the edge that writes the last word. req_ready stays 0 throughout.
  - READY: req_ready=1 and init_done=1. Stays in READY until reset.
  - Reset asserted during CLEAR restarts the clear from index 0 after release.
- Word index is req_addr[log2(DEPTH_WORDS)+1:2]. Byte lane k = req_addr[1:0] occupies bits 8k+7:8k.
- Fault (resp_err=1) is raised for any of:
  - req_size=11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - any ADDR_W bit above the index field set
- A faulting store writes nothing. A faulting load returns 0.
- Stores:
  - Byte writes lane addr[1:0] with wdata[7:0].
  - Half writes lanes addr[1]*2 and addr[1]*2+1 with wdata[15:0].
  - Word writes all lanes.
  - Unselected lanes keep their contents.
  - The write commits on the acceptance edge.
- Loads:
  - The word is read at the acceptance edge, then the selected lane(s) are shifted down and extended per req_unsigned.
  - The formatted result is registered into pipeline stage 1 on that edge.
- Every accepted request, load or store, produces exactly one response. resp_valid is asserted exactly READ_LATENCY cycles after the acceptance edge, and responses stay in acceptance order. Back-to-back requests give back-to-back responses.
- Same-edge ordering: a load accepted on the edge after a store to the same word sees the stored data. Only one request can be accepted per edge, so same-edge conflicts cannot occur.
- Store responses carry rdata=0 and err per the fault rules.

Decomposition:
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the legal READ_LATENCY bounds.
- One sub-module, mem_load_align: a combinational lane extract and sign/zero extend, reused by the later cache fill path.
- The FSM, byte-lane write enables and response delay pipeline stay in the top module.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH_WORDS=16: release reset → req_ready=0 for exactly 16 cycles, then init_done=1. A word load from 0x3C then returns 0x00000000.
- Word store 0x11223344 to 0x100, then byte store 0xAA to 0x101, then word load 0x100 → 0x1122AA44. Half load 0x102, signed → 0x00001122.
- With memory 0x80FF7F01 at 0x200:
  - lb 0x201 → 0x0000007F
  - lb 0x203 → 0xFFFFFF80
  - lbu 0x203 → 0x00000080
  - lh 0x202 → 0xFFFF80FF
- Word load 0x102, half store 0x203, size 11, and address 0x4000 with DEPTH_WORDS=4096 → each gives resp_err=1 and rdata=0, and memory is unchanged on readback.
- READ_LATENCY=3: four back-to-back loads → resp_valid high on cycles 3..6 after the first acceptance, data returned in order.
- Assert rst_n mid-CLEAR at index 5 → outputs go to zero immediately. After release the clear restarts and takes the full DEPTH_WORDS cycles.

Source files
------------

// File: rtl/data_memory_lanes_pkg.sv
// Shared definitions for the lane-masked data memory: access size encodings,
// latency bounds, FSM states, the response record and small lane helpers.
package data_memory_lanes_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } mem_size_e;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } mem_resp_t;

    // True when the access cannot be performed at this byte offset; the
    // illegal size encoding always counts as a fault.
    function automatic logic size_misaligned(input mem_size_e size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: size_misaligned = 1'b0;
            SZ_HALF: size_misaligned = offset[0];
            SZ_WORD: size_misaligned = |offset;
            default: size_misaligned = 1'b1;
        endcase
    endfunction

    // Byte-lane write enables for a store of the given size at the given offset.
    function automatic logic [3:0] lane_enables(input mem_size_e size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: lane_enables = 4'b0001 << offset;
            SZ_HALF: lane_enables = offset[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_enables = 4'b1111;
            default: lane_enables = 4'b0000;
        endcase
    endfunction

    // Replicate right-justified store data across the lanes so that whichever
    // lanes are enabled already hold the right bytes.
    function automatic logic [31:0] lane_replicate(input mem_size_e size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: lane_replicate = {4{wdata[7:0]}};
            SZ_HALF: lane_replicate = {2{wdata[15:0]}};
            default: lane_replicate = wdata;
        endcase
    endfunction

endpackage

// File: rtl/data_memory_lanes_mem_load_align.sv
// Combinational load formatter: shifts the addressed lane(s) of a 32-bit word
// down to bit 0 and sign- or zero-extends them. Shared with the cache fill path.
module mem_load_align
    import data_memory_lanes_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  mem_size_e   size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic        fill_byte;
    logic        fill_half;

    assign shifted   = word_i >> {offset_i, 3'b000};
    assign fill_byte = ~unsigned_i & shifted[7];
    assign fill_half = ~unsigned_i & shifted[15];

    // Pick the extension width from the access size.
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        data_o = shifted;
        case (size_i)
            SZ_BYTE: data_o = {{24{fill_byte}}, shifted[7:0]};
            SZ_HALF: data_o = {{16{fill_half}}, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/data_memory_lanes.sv
// Byte-addressable little-endian data memory with byte-lane stores, extended
// loads, a valid/ready request port, a fixed-latency in-order response
// pipeline, an optional post-reset clear sweep and fault reporting.
module data_memory_lanes
    import data_memory_lanes_pkg::*;
#(
    parameter int    DEPTH_WORDS    = 4096,
    parameter int    ADDR_W         = 32,
    parameter int    READ_LATENCY   = 1,
    parameter bit    CLEAR_ON_RESET = 1'b0,
    parameter string INIT_FILE      = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              init_done
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LAT   = (READ_LATENCY < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
                           (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX : READ_LATENCY;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    logic [31:0]      mem_q [DEPTH_WORDS];

    mem_state_e       state_q;
    logic [IDX_W-1:0] clr_idx_q;
    logic             req_ready_q;
    logic             init_done_q;

    mem_size_e        size;
    logic [1:0]       offset;
    logic [IDX_W-1:0] req_idx;
    logic             range_err;
    logic             fault;
    logic             accept;
    logic             clearing;

    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;

    logic [31:0]      rd_word;
    logic [31:0]      load_data;
    mem_resp_t        stage_in;
    mem_resp_t        pipe_q [LAT];

    assign size     = mem_size_e'(req_size);
    assign offset   = req_addr[1:0];
    assign req_idx  = req_addr[IDX_W+1:2];
    assign accept   = req_valid & req_ready_q;
    assign clearing = (state_q == ST_CLEAR);

    // Any address bit above the word-index field means the access is out of range.
    if (ADDR_W > IDX_W + 2) begin : g_range
        assign range_err = |req_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_range
        assign range_err = 1'b0;
    end

    assign fault = range_err | size_misaligned(size, offset);

    // Single write port: the clear sweep owns it while clearing, otherwise an
    // accepted, non-faulting store drives it with its lane mask.
    always_comb begin
        wr_idx  = req_idx;
        wr_be   = 4'b0000;
        wr_data = lane_replicate(size, req_wdata);
        if (clearing) begin
            wr_idx  = clr_idx_q;
            wr_be   = 4'b1111;
            wr_data = 32'h0;
        end else if (accept && req_write && !fault) begin
            wr_be = lane_enables(size, offset);
        end
    end

    // Byte-lane masked array write; unselected lanes keep their contents.
    // NOTE: the array has no reset -- rst_n must not disturb its contents, and a reset would stop RAM inference.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_be[k]) begin
                mem_q[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    // Read the addressed word as it stands before this edge's write; a store
    // accepted on an earlier edge is therefore already visible.
    assign rd_word = mem_q[req_idx];

    mem_load_align u_align (
        .word_i     (rd_word),
        .offset_i   (offset),
        .size_i     (size),
        .unsigned_i (req_unsigned),
        .data_o     (load_data)
    );

    assign stage_in.valid = accept;
    assign stage_in.err   = accept & fault;
    assign stage_in.rdata = (accept && !req_write && !fault) ? load_data : 32'h0;

    // Fixed-length response delay line; one entry per accepted request keeps order.
    // NOTE: sequential state is assigned with <= so every stage samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= stage_in;
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Init sequencer: optional clear sweep after reset, then accept requests forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RESET;
            clr_idx_q   <= '0;
            req_ready_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    clr_idx_q <= '0;
                    if (CLEAR_ON_RESET) begin
                        state_q <= ST_CLEAR;
                    end else begin
                        state_q     <= ST_READY;
                        req_ready_q <= 1'b1;
                        init_done_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_idx_q == LAST_IDX) begin
                        state_q     <= ST_READY;
                        req_ready_q <= 1'b1;
                        init_done_q <= 1'b1;
                    end else begin
                        clr_idx_q <= clr_idx_q + 1'b1;
                    end
                end
                ST_READY: begin
                    req_ready_q <= 1'b1;
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_RESET;
                    req_ready_q <= 1'b0;
                    init_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign init_done  = init_done_q;
    assign resp_valid = pipe_q[LAT-1].valid;
    assign resp_err   = pipe_q[LAT-1].err;
    assign resp_rdata = pipe_q[LAT-1].rdata;

endmodule

// File: tb/tb_data_memory_lanes.sv
// Bench for data_memory_lanes: a small clearing instance (latency 1) for the
// clear/reset behaviour and a full-size instance (latency 3) checked every
// cycle against a byte-array reference model under directed and random traffic.
module tb_data_memory_lanes;
    import data_memory_lanes_pkg::*;

    localparam int S_DEPTH = 16;
    localparam int M_DEPTH = 4096;
    localparam int M_LAT   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // ---------------- small instance ----------------
    logic        s_rst_n = 1'b0;
    logic        s_req_valid = 1'b0, s_req_write = 1'b0, s_req_unsigned = 1'b0;
    logic [1:0]  s_req_size = 2'b10;
    logic [31:0] s_req_addr = '0, s_req_wdata = '0;
    logic        s_req_ready, s_resp_valid, s_resp_err, s_init_done;
    logic [31:0] s_resp_rdata;

    data_memory_lanes #(
        .DEPTH_WORDS(S_DEPTH), .ADDR_W(32), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1), .INIT_FILE("")
    ) u_small (
        .clk(clk), .rst_n(s_rst_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_write(s_req_write),
        .req_size(s_req_size), .req_unsigned(s_req_unsigned), .req_addr(s_req_addr),
        .req_wdata(s_req_wdata), .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata),
        .resp_err(s_resp_err), .init_done(s_init_done)
    );

    // ---------------- main instance ----------------
    logic        m_rst_n = 1'b0;
    logic        m_req_valid = 1'b0, m_req_write = 1'b0, m_req_unsigned = 1'b0;
    logic [1:0]  m_req_size = 2'b10;
    logic [31:0] m_req_addr = '0, m_req_wdata = '0;
    logic        m_req_ready, m_resp_valid, m_resp_err, m_init_done;
    logic [31:0] m_resp_rdata;

    data_memory_lanes #(
        .DEPTH_WORDS(M_DEPTH), .ADDR_W(32), .READ_LATENCY(M_LAT), .CLEAR_ON_RESET(1'b1), .INIT_FILE("")
    ) u_main (
        .clk(clk), .rst_n(m_rst_n),
        .req_valid(m_req_valid), .req_ready(m_req_ready), .req_write(m_req_write),
        .req_size(m_req_size), .req_unsigned(m_req_unsigned), .req_addr(m_req_addr),
        .req_wdata(m_req_wdata), .resp_valid(m_resp_valid), .resp_rdata(m_resp_rdata),
        .resp_err(m_resp_err), .init_done(m_init_done)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%08h expected=%08h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model (main instance) ----------------
    // Flat little-endian byte array; starts all zero because the DUT clears itself.
    logic [7:0] mem_m [M_DEPTH*4];
    initial foreach (mem_m[i]) mem_m[i] = 8'h00;

    function automatic void model_access(input logic wr, input logic [1:0] sz, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic err);
        int nb;
        longint unsigned v;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = (sz == 2'd3) || ((addr % nb) != 0) || (addr >= 32'(M_DEPTH * 4));
        rd  = 32'h0;
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < nb; i++) mem_m[addr + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v = v | (longint'(mem_m[addr + i]) << (8 * i));
                if (!uns && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
                rd = v[31:0];
            end
        end
    endfunction

    typedef struct {
        int unsigned due;
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];
    bit   cmp_en = 1'b0;

    // Every cycle: either the oldest outstanding response is due now, or nothing may be presented.
    always @(negedge clk) begin
        if (cmp_en) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check("m_resp_valid", {31'b0, m_resp_valid}, 32'd1);
                check("m_resp_rdata", m_resp_rdata, exp_q[0].rdata);
                check("m_resp_err", {31'b0, m_resp_err}, {31'b0, exp_q[0].err});
                void'(exp_q.pop_front());
            end else begin
                check("m_resp_idle", {31'b0, m_resp_valid}, 32'd0);
            end
        end
    end

    task automatic m_issue(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic err);
        exp_t e;
        @(negedge clk);
        check("m_req_ready", {31'b0, m_req_ready}, 32'd1);
        m_req_valid = 1'b1; m_req_write = wr; m_req_size = sz;
        m_req_unsigned = uns; m_req_addr = addr; m_req_wdata = wd;
        model_access(wr, sz, uns, addr, wd, rd, err);
        e.due = cyc + M_LAT; e.rdata = rd; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic m_idle();
        @(negedge clk);
        m_req_valid = 1'b0;
    endtask

    // ---------------- small instance helpers ----------------
    task automatic s_op(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic vld, output logic [31:0] rd, output logic err);
        @(negedge clk);
        s_req_valid = 1'b1; s_req_write = wr; s_req_size = sz;
        s_req_unsigned = uns; s_req_addr = addr; s_req_wdata = wd;
        @(negedge clk);
        s_req_valid = 1'b0;
        vld = s_resp_valid; rd = s_resp_rdata; err = s_resp_err;
    endtask

    // Called right after release at a falling edge: skips the leaving-reset edge,
    // then counts cycles with req_ready low.
    task automatic s_count_clear(output int n);
        @(posedge clk);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (s_req_ready) break;
            n++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err, vld;
        int          n;

        // ---------- small instance: reset state and clear sweep ----------
        repeat (2) @(negedge clk);
        check("s_rst_ready", {31'b0, s_req_ready}, 32'd0);
        check("s_rst_init_done", {31'b0, s_init_done}, 32'd0);
        check("s_rst_resp_valid", {31'b0, s_resp_valid}, 32'd0);
        check("s_rst_resp_rdata", s_resp_rdata, 32'd0);
        check("s_rst_resp_err", {31'b0, s_resp_err}, 32'd0);
        check("m_rst_ready", {31'b0, m_req_ready}, 32'd0);
        check("m_rst_init_done", {31'b0, m_init_done}, 32'd0);

        s_rst_n = 1'b1;
        s_count_clear(n);
        check("s_clear_cycles", n, S_DEPTH);
        check("s_init_done", {31'b0, s_init_done}, 32'd1);

        s_op(1'b1, SZ_WORD, 1'b0, 32'h3C, 32'hDEADBEEF, vld, rd, err);
        check("s_store_valid", {31'b0, vld}, 32'd1);
        check("s_store_rdata", rd, 32'd0);
        check("s_store_err", {31'b0, err}, 32'd0);
        s_op(1'b0, SZ_WORD, 1'b0, 32'h3C, 32'h0, vld, rd, err);
        check("s_load_3c", rd, 32'hDEADBEEF);
        s_op(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, vld, rd, err);
        check("s_range_err", {31'b0, err}, 32'd1);
        check("s_range_rdata", rd, 32'd0);

        // Reset while a response is being presented empties the pipeline at once.
        @(negedge clk);
        s_req_valid = 1'b1; s_req_write = 1'b0; s_req_size = SZ_WORD; s_req_addr = 32'h3C;
        @(posedge clk);
        #1;
        s_req_valid = 1'b0;
        check("s_inflight_valid", {31'b0, s_resp_valid}, 32'd1);
        s_rst_n = 1'b0;
        #1;
        check("s_async_resp_valid", {31'b0, s_resp_valid}, 32'd0);
        check("s_async_resp_rdata", s_resp_rdata, 32'd0);
        check("s_async_ready", {31'b0, s_req_ready}, 32'd0);

        // Release, then abort the sweep while it is at word index 5.
        @(negedge clk);
        s_rst_n = 1'b1;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #2;
        check("s_midclear_ready", {31'b0, s_req_ready}, 32'd0);
        s_rst_n = 1'b0;
        #1;
        check("s_midclear_rst_ready", {31'b0, s_req_ready}, 32'd0);
        check("s_midclear_rst_done", {31'b0, s_init_done}, 32'd0);
        check("s_midclear_rst_valid", {31'b0, s_resp_valid}, 32'd0);
        @(negedge clk);
        s_rst_n = 1'b1;
        s_count_clear(n);
        check("s_reclear_cycles", n, S_DEPTH);
        s_op(1'b0, SZ_WORD, 1'b0, 32'h3C, 32'h0, vld, rd, err);
        check("s_reclear_load_3c", rd, 32'h0);
        check("s_reclear_load_valid", {31'b0, vld}, 32'd1);

        // ---------- main instance ----------
        @(negedge clk);
        m_rst_n = 1'b1;
        n = 0;
        while (!m_init_done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("m_init_done", {31'b0, m_init_done}, 32'd1);
        cmp_en = 1'b1;

        // Directed traffic; literal pins confirm the model, the compare process checks the DUT.
        m_issue(1'b1, SZ_WORD, 1'b0, 32'h100, 32'h11223344, rd, err);
        m_issue(1'b1, SZ_BYTE, 1'b0, 32'h101, 32'h000000AA, rd, err);
        m_issue(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, rd, err);
        check("pin_lw_100", rd, 32'h1122AA44);
        m_issue(1'b0, SZ_HALF, 1'b0, 32'h102, 32'h0, rd, err);
        check("pin_lh_102", rd, 32'h00001122);
        m_issue(1'b1, SZ_WORD, 1'b0, 32'h200, 32'h80FF7F01, rd, err);
        m_issue(1'b0, SZ_BYTE, 1'b0, 32'h201, 32'h0, rd, err);
        check("pin_lb_201", rd, 32'h0000007F);
        m_issue(1'b0, SZ_BYTE, 1'b0, 32'h203, 32'h0, rd, err);
        check("pin_lb_203", rd, 32'hFFFFFF80);
        m_issue(1'b0, SZ_BYTE, 1'b1, 32'h203, 32'h0, rd, err);
        check("pin_lbu_203", rd, 32'h00000080);
        m_issue(1'b0, SZ_HALF, 1'b0, 32'h202, 32'h0, rd, err);
        check("pin_lh_202", rd, 32'hFFFF80FF);

        // Faults: nothing written, zero data.
        m_issue(1'b0, SZ_WORD, 1'b0, 32'h102, 32'h0, rd, err);
        check("pin_err_lw_102", {31'b0, err}, 32'd1);
        m_issue(1'b1, SZ_HALF, 1'b0, 32'h203, 32'h00005555, rd, err);
        check("pin_err_sh_203", {31'b0, err}, 32'd1);
        m_issue(1'b1, SZ_BAD, 1'b0, 32'h100, 32'hFFFFFFFF, rd, err);
        check("pin_err_size11", {31'b0, err}, 32'd1);
        m_issue(1'b1, SZ_WORD, 1'b0, 32'h4000, 32'hCAFEBABE, rd, err);
        check("pin_err_range", {31'b0, err}, 32'd1);
        m_issue(1'b0, SZ_WORD, 1'b0, 32'h200, 32'h0, rd, err);
        check("pin_readback_200", rd, 32'h80FF7F01);
        m_issue(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, rd, err);
        check("pin_readback_100", rd, 32'h1122AA44);
        m_issue(1'b0, SZ_WORD, 1'b0, 32'h000, 32'h0, rd, err);
        check("pin_readback_000", rd, 32'h00000000);
        m_idle();
        repeat (2) m_idle();

        // Four back-to-back loads after an idle gap: responses on consecutive cycles, in order.
        for (int i = 0; i < 4; i++) m_issue(1'b0, SZ_BYTE, 1'b1, 32'h200 + i, 32'h0, rd, err);
        m_idle();

        // Random traffic concentrated on a small window, with idles and bad requests.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 3) == 0) begin
                m_idle();
            end else begin
                a = 32'h300 + $urandom_range(0, 31);
                if ($urandom_range(0, 15) == 0) a = $urandom() | 32'h4000;
                m_issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        a, $urandom(), rd, err);
            end
        end
        m_idle();
        repeat (M_LAT + 3) @(negedge clk);
        check("m_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
